// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulator sequencer.
package acc_seq_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        OP_CLR = 2'd0,
        OP_MUL = 2'd1,
        OP_MAC = 2'd2,
        OP_INC = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/acc_seq_cnt.sv
// Loadable W-bit down-counter used as the iteration timer of the sequencer.
module acc_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (dec && (q != '0)) begin
            q <= q - W'(1);
        end
    end

    assign is_one = (q == W'(1));

endmodule

// File: rtl/acc_sequencer.sv
// Command-driven sequencer for the accumulator datapath: clear, repeated add and
// repeated increment, returning the final value and a sticky carry-out flag.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// CLEAR | one cycle adding the negated accumulator value so it becomes zero
// RUN   | one add (s1) or increment (s2) step per cycle until the counter hits 1
// RESP  | result presented until rsp_ready
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_ovf,
    output logic         acc_s1,
    output logic         acc_s2,
    output logic [W-1:0] acc_r2,
    input  logic [W-1:0] acc_r1
);

    state_t       state, state_d;
    op_t          op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         ovf_q;

    logic         accept;
    logic         cnt_dec;
    logic [W-1:0] cnt_q;
    logic         cnt_is_one;
    logic         run_carry;
    logic [W:0]   add_sum;

    assign accept  = cmd_valid && (state == IDLE);
    assign add_sum = {1'b0, acc_r1} + {1'b0, a_q};

    acc_seq_cnt #(.W(W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .dec    (cnt_dec),
        .d      (cmd_b),
        .q      (cnt_q),
        .is_one (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_CLR;
            a_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                ovf_q <= 1'b0;
            end else if ((state == RUN) && run_carry) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_ovf   = 1'b0;
        acc_s1    = 1'b0;
        acc_s2    = 1'b0;
        acc_r2    = '0;
        cnt_dec   = 1'b0;
        run_carry = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if ((op_t'(cmd_op) == OP_CLR) || (op_t'(cmd_op) == OP_MUL)) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = (cmd_b != '0) ? RUN : RESP;
                    end
                end
            end
            CLEAR: begin
                // Carry out of the negation step is deliberately not recorded.
                acc_s1  = 1'b1;
                acc_r2  = ~acc_r1 + W'(1);
                state_d = ((op_q == OP_MUL) && (b_q != '0)) ? RUN : RESP;
            end
            RUN: begin
                cnt_dec = 1'b1;
                if (op_q == OP_INC) begin
                    acc_s2    = 1'b1;
                    run_carry = &acc_r1;
                end else begin
                    acc_s1    = 1'b1;
                    acc_r2    = a_q;
                    run_carry = add_sum[W];
                end
                if (cnt_is_one) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = acc_r1;
                rsp_ovf   = ovf_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench: acc_sequencer paired with a behavioural 4-bit accumulator.
module tb_acc_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;
    logic         acc_s1;
    logic         acc_s2;
    logic [W-1:0] acc_r2;
    logic [W-1:0] acc_r1;

    logic [W-1:0] acc;
    logic         acc_load = 1'b0;
    logic [W-1:0] acc_load_val = '0;

    int checks = 0;
    int errors = 0;
    int model_acc = 0;

    always #5 clk = ~clk;

    acc_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .acc_s1    (acc_s1),
        .acc_s2    (acc_s2),
        .acc_r2    (acc_r2),
        .acc_r1    (acc_r1)
    );

    // Behavioural accumulator with its own preset, independent of rst.
    always @(posedge clk) begin
        if (acc_load)    acc <= acc_load_val;
        else if (acc_s1) acc <= acc + acc_r2;
        else if (acc_s2) acc <= acc + 4'd1;
    end
    assign acc_r1 = acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preset(input int v);
        @(negedge clk);
        acc_load = 1'b1;
        acc_load_val = 4'(v);
        @(negedge clk);
        acc_load = 1'b0;
        model_acc = v;
    endtask

    // Issue one command, check every cycle until the response, optionally stall it.
    task automatic run_cmd(input int op, input int a, input int b, input int hold);
        int prior, sum, expd, explat, k;
        logic expovf, es1, es2, seen;
        logic [3:0] exp_r2;
        prior = model_acc;
        case (op)
            0:       begin sum = 0;             explat = 2;     end
            1:       begin sum = a * b;         explat = b + 2; end
            2:       begin sum = prior + a * b; explat = b + 1; end
            default: begin sum = prior + b;     explat = b + 1; end
        endcase
        expd   = sum % 16;
        expovf = (sum >= 16);

        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_a     = 4'(a);
        cmd_b     = 4'(b);
        @(posedge clk);
        k = 1;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                es1 = 1'b0; es2 = 1'b0; exp_r2 = 4'd0;
                if ((op == 0 || op == 1) && k == 1) begin
                    es1 = 1'b1; exp_r2 = 4'(16 - prior);
                end else if (op == 1 && k <= b + 1) begin
                    es1 = 1'b1; exp_r2 = 4'(a);
                end else if (op == 2 && k <= b) begin
                    es1 = 1'b1; exp_r2 = 4'(a);
                end else if (op == 3 && k <= b) begin
                    es2 = 1'b1;
                end
                check("ctl_s1_s2_r2", {acc_s1, acc_s2, acc_r2}, {es1, es2, exp_r2});
                check("busy_ready", cmd_ready, 0);
                k++;
            end
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = 4'($urandom_range(0, 15));
        end
        if (!seen) begin
            check("rsp_timeout", rsp_valid, 1);
        end else begin
            check("rsp_latency", k, explat);
            check("rsp_data", rsp_data, expd);
            check("rsp_ovf", rsp_ovf, expovf);
            check("rsp_ctl_idle", {acc_s1, acc_s2, acc_r2, cmd_ready}, 0);
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("hold_stable", {rsp_valid, rsp_data, rsp_ovf, acc_s1, acc_s2, cmd_ready},
                  {1'b1, 4'(expd), expovf, 3'b000});
        end
        rsp_ready = 1'b1;
        cmd_valid = (hold > 0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_handshake", {cmd_ready, rsp_valid, rsp_data, rsp_ovf}, {1'b1, 1'b0, 4'h0, 1'b0});
        check("acc_value", acc, expd);
        model_acc = expd;
    endtask

    initial begin
        int spurious;
        acc_load = 1'b1;
        acc_load_val = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        acc_load = 1'b0;
        check("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_ovf, acc_s1, acc_s2, acc_r2},
              {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0});

        preset(5);
        run_cmd(0, 0, 0, 0);          // CLR from 5: r2=B then result 0
        preset(9);
        run_cmd(1, 3, 4, 0);          // MUL 3*4 = 12
        run_cmd(1, 5, 4, 0);          // MUL 5*4 wraps to 4 with overflow
        preset(4);
        run_cmd(2, 2, 3, 0);          // MAC 4 + 6 = 10
        run_cmd(3, 0, 0, 0);          // INC b=0 keeps 10, no s2 pulse
        run_cmd(2, 3, 2, 5);          // MAC 10 + 6 wraps to 0, response stalled 5 cycles

        // Reset in the fourth cycle of a long MUL drops the command.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        cmd_a = 4'd1;
        cmd_b = 4'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_idle", {cmd_ready, acc_s1, acc_s2, rsp_valid}, {1'b1, 1'b0, 1'b0, 1'b0});
        check("rst_mid_acc", acc, 3);
        spurious = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) spurious++;
        end
        check("rst_no_response", spurious, 0);
        model_acc = 3;

        for (int i = 0; i < 25; i++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Controller for the 4-bit accumulator datapath: it drives the accumulator's add-operand (`s1`/`r2`) and increment (`s2`) controls, and reads the accumulator value `r1` back. It accepts one command at a time over a valid/ready handshake and sequences the datapath through clear, repeated-add and repeated-increment steps. It returns the final accumulator value and an overflow flag over a second valid/ready handshake. It sits between the command source and the accumulator instance.

## Interface
Parameters:
- `W`, default 4: datapath width. This is the width of the accumulator, of the operands and of the iteration count.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  a command is offered
- `cmd_ready`  out  1  the block can accept a command; high only in IDLE
- `cmd_op`  in  2  opcode: CLR=0, MUL=1, MAC=2, INC=3
- `cmd_a`  in  W  add operand
- `cmd_b`  in  W  iteration count
- `rsp_valid`  out  1  a result is presented
- `rsp_ready`  in  1  the consumer takes the result
- `rsp_data`  out  W  result, equal to `acc_r1` while in RESP; 0 otherwise
- `rsp_ovf`  out  1  sticky carry-out flag for the current command; 0 outside RESP
- `acc_s1`  out  1  to accumulator `s1`: add `acc_r2`
- `acc_s2`  out  1  to accumulator `s2`: add 1
- `acc_r2`  out  W  to accumulator `r2`
- `acc_r1`  in  W  accumulator value readback

## Operation
- FSM states: IDLE, CLEAR, RUN, RESP.
- Acceptance: a command is accepted on the edge where `cmd_valid && cmd_ready`. On that edge the block latches `cmd_op`, `cmd_a` and `cmd_b`, loads the down-counter with `cmd_b`, and clears the overflow flag.
- Transitions out of IDLE on acceptance:
  - CLR and MUL go to CLEAR.
  - MAC and INC go to RUN if `b != 0`, otherwise straight to RESP.
- CLEAR (one cycle):
  - Drives `acc_s1=1` and `acc_r2 = ~acc_r1 + 1` (two's-complement negation), so the accumulator becomes 0.
  - The carry out of this step is ignored.
  - Next state: CLR goes to RESP. MUL goes to RUN if `b != 0`, otherwise to RESP.
- RUN (one cycle per iteration):
  - MUL and MAC drive `acc_s1=1` and `acc_r2=a`.
  - INC drives `acc_s2=1` and `acc_r2=0`.
  - The counter decrements each cycle. Leave RUN for RESP in the cycle the counter equals 1.
- Overflow is set in any RUN cycle where `acc_r1 + acc_r2 >= 2^W` (s1 step) or `acc_r1 == 2^W-1` (s2 step). It stays set until the next acceptance.
- RESP:
  - `acc_s1 = acc_s2 = 0`, so `acc_r1` is stable.
  - `rsp_valid=1`, `rsp_data=acc_r1`, `rsp_ovf` = the overflow flag.
  - Hold these until `rsp_ready`, then go to IDLE.
- Outside CLEAR and RUN: `acc_s1 = acc_s2 = 0` and `acc_r2 = 0`. `acc_s1` and `acc_s2` are never high together.
- Results are modulo 2^W:
  - MUL gives `a*b`.
  - MAC gives prior acc + `a*b`.
  - INC gives prior acc + `b`.
- The accumulator's own reset is separate from `rst`. MAC and INC therefore operate on whatever value the accumulator holds; MUL and CLR never depend on the prior value.

## Timing
- Cycle k means the k-th cycle after the acceptance edge.
- `rsp_valid` first goes high in:
  - CLR: cycle 2.
  - MUL: cycle b+2.
  - MAC and INC: cycle b+1. With b=0 this is cycle 1.
- `cmd_ready` is low from cycle 1 until the cycle after the RESP handshake. No command is accepted in the handshake cycle itself.
- `cmd_valid` is ignored while the block is not in IDLE.
- Reset values: state=IDLE, `cmd_ready=1`, `rsp_valid=0`, `rsp_data=0`, `rsp_ovf=0`, `acc_s1=0`, `acc_s2=0`, `acc_r2=0`, counter=0, overflow flag=0.
- `rst` during any state: the block is in IDLE in the cycle after the reset edge, with all controls deasserted. The in-flight command is dropped and no response is produced. The accumulator keeps the value left by the last issued step.

## Structure
- Package `acc_seq_pkg` holds:
  - `op_t` enum (CLR, MUL, MAC, INC).
  - `state_t` enum (IDLE, CLEAR, RUN, RESP).
  - The default width constant.
- One sub-module, `acc_seq_cnt`: a W-bit loadable down-counter with `load`, `dec`, `q` and `is_one` outputs.
- The FSM, operand latches and overflow logic live in the top module.
- The bench pairs the block with a behavioral 4-bit accumulator whose `r1` feeds `acc_r1`.

## Test plan
- Accumulator preset to 5, CLR issued:
  - Cycle 1: `acc_s1=1`, `acc_r2=4'hB`.
  - Cycle 2: `rsp_valid=1`, `rsp_data=0`, `rsp_ovf=0`.
- MUL a=3, b=4 (accumulator at 9):
  - Cycle 1: clear.
  - Cycles 2–5: `acc_s1=1`, `acc_r2=3`.
  - Cycle 6: `rsp_data=12`, `rsp_ovf=0`.
- MUL a=5, b=4: cycle 6 gives `rsp_data=4` (20 mod 16), `rsp_ovf=1`.
- MAC a=2, b=3 from accumulator 4: `rsp_data=10` in cycle 4. Then INC b=0: `rsp_data=10` in cycle 1, with no `acc_s2` pulse.
- Hold `rsp_ready=0` for 5 cycles with `cmd_valid=1`:
  - `rsp_valid`, `rsp_data` and `rsp_ovf` stay stable.
  - `acc_s1 = acc_s2 = 0`, `cmd_ready=0`, and no command is accepted.
- MUL a=1, b=10, then `rst` in cycle 4: in the next cycle the state is IDLE, `cmd_ready=1`, `acc_s1=0`, `rsp_valid=0`, and no response follows.
